// File: rtl/out_sched.sv
// out_sched: two-requester round-robin scheduler feeding a 128->16 serializer.
// Each requester owns one holding slot (data + type + full flag). A load
// strobe is issued at most once every SLOT cycles, so a serializer that
// drains 16 bits per cycle gets a new 128-bit block exactly when it runs dry.
module out_sched #(
  parameter int SLOT = 8,
  parameter int CW   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_v,
  input  logic         req0_t,
  input  logic [127:0] req0_d,
  output logic         req0_rdy,
  input  logic         req1_v,
  input  logic         req1_t,
  input  logic [127:0] req1_d,
  output logic         req1_rdy,
  output logic         ser_vin,
  output logic         ser_tin,
  output logic [127:0] ser_din,
  output logic         ser_src,
  output logic         busy
);

  // Slot counter constants, sized to the counter so SLOT/CW overrides stay consistent.
  localparam logic [CW-1:0] CNT_LOAD = CW'(SLOT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  // Holding slot 0
  logic         full0_r;
  logic [127:0] hold0_d_r;
  logic         hold0_t_r;
  // Holding slot 1
  logic         full1_r;
  logic [127:0] hold1_d_r;
  logic         hold1_t_r;
  // Pacing and arbitration state
  logic [CW-1:0] cnt_r;
  logic          lp_r;

  // Combinational decisions for the coming edge
  logic         acc0_s;
  logic         acc1_s;
  logic         grant_s;
  logic         gsel_s;
  logic [127:0] sel_d_s;
  logic         sel_t_s;

  // Accept/grant decision: accepts only into empty slots, grant only from full
  // ones, so a slot can never be accepted into and granted in the same cycle.
  always_comb begin
    acc0_s  = req0_v & ~full0_r;
    acc1_s  = req1_v & ~full1_r;
    grant_s = (cnt_r == CNT_ZERO) & (full0_r | full1_r);
    if (full0_r && full1_r) begin
      // both pending: alternate away from the last winner
      gsel_s = ~lp_r;
    end else if (full1_r) begin
      gsel_s = 1'b1;
    end else begin
      gsel_s = 1'b0;
    end
    if (gsel_s) begin
      sel_d_s = hold1_d_r;
      sel_t_s = hold1_t_r;
    end else begin
      sel_d_s = hold0_d_r;
      sel_t_s = hold0_t_r;
    end
  end

  // Holding slot 0: capture on accept, release when granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      full0_r   <= 1'b0;
      hold0_d_r <= 128'd0;
      hold0_t_r <= 1'b0;
    end else if (acc0_s) begin
      full0_r   <= 1'b1;
      hold0_d_r <= req0_d;
      hold0_t_r <= req0_t;
    end else if (grant_s && !gsel_s) begin
      full0_r <= 1'b0;
    end
  end

  // Holding slot 1: capture on accept, release when granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      full1_r   <= 1'b0;
      hold1_d_r <= 128'd0;
      hold1_t_r <= 1'b0;
    end else if (acc1_s) begin
      full1_r   <= 1'b1;
      hold1_d_r <= req1_d;
      hold1_t_r <= req1_t;
    end else if (grant_s && gsel_s) begin
      full1_r <= 1'b0;
    end
  end

  // Slot pacing counter: reload on grant, otherwise count down to zero and stay.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (grant_s) begin
      cnt_r <= CNT_LOAD;
    end else if (cnt_r != CNT_ZERO) begin
      cnt_r <= cnt_r - CNT_ONE;
    end
  end

  // Last-granted pointer; resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      lp_r <= 1'b1;
    end else if (grant_s) begin
      lp_r <= gsel_s;
    end
  end

  // Serializer load port: one-cycle strobe per grant, payload held between loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      ser_vin <= 1'b0;
      ser_tin <= 1'b0;
      ser_din <= 128'd0;
      ser_src <= 1'b0;
    end else if (grant_s) begin
      ser_vin <= 1'b1;
      ser_tin <= sel_t_s;
      ser_din <= sel_d_s;
      ser_src <= gsel_s;
    end else begin
      ser_vin <= 1'b0;
    end
  end

  // Ready and busy are decoded straight from flops, independent of reqN_v.
  assign req0_rdy = ~full0_r;
  assign req1_rdy = ~full1_r;
  assign busy     = full0_r | full1_r | (cnt_r != CNT_ZERO);

endmodule

// File: tb/tb_out_sched.sv
// Directed testbench for out_sched (SLOT=8 main instance, SLOT=4 second instance).
module tb_out_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req0_v, req0_t, req0_rdy;
  logic [127:0] req0_d;
  logic         req1_v, req1_t, req1_rdy;
  logic [127:0] req1_d;
  logic         ser_vin, ser_tin, ser_src, busy;
  logic [127:0] ser_din;

  logic         s4_req0_v, s4_req0_t, s4_req0_rdy;
  logic [127:0] s4_req0_d;
  logic         s4_req1_v, s4_req1_t, s4_req1_rdy;
  logic [127:0] s4_req1_d;
  logic         s4_ser_vin, s4_ser_tin, s4_ser_src, s4_busy;
  logic [127:0] s4_ser_din;

  int errors = 0;
  int checks = 0;

  out_sched #(.SLOT(8), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .req0_v(req0_v), .req0_t(req0_t), .req0_d(req0_d), .req0_rdy(req0_rdy),
    .req1_v(req1_v), .req1_t(req1_t), .req1_d(req1_d), .req1_rdy(req1_rdy),
    .ser_vin(ser_vin), .ser_tin(ser_tin), .ser_din(ser_din), .ser_src(ser_src),
    .busy(busy)
  );

  out_sched #(.SLOT(4), .CW(2)) dut4 (
    .clk(clk), .rst(rst),
    .req0_v(s4_req0_v), .req0_t(s4_req0_t), .req0_d(s4_req0_d), .req0_rdy(s4_req0_rdy),
    .req1_v(s4_req1_v), .req1_t(s4_req1_t), .req1_d(s4_req1_d), .req1_rdy(s4_req1_rdy),
    .ser_vin(s4_ser_vin), .ser_tin(s4_ser_tin), .ser_din(s4_ser_din), .ser_src(s4_ser_src),
    .busy(s4_busy)
  );

  localparam logic [127:0] DA = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] DB = 128'hFFEEDDCCBBAA99887766554433221100;

  function automatic logic [127:0] mk(input bit s, input int n);
    logic [31:0] nn;
    nn = n;
    return {(s ? 32'h5555_0001 : 32'hAAAA_0000), 64'h0123_4567_89AB_CDEF, nn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_v = 1'b0; req0_t = 1'b0; req0_d = 128'd0;
    req1_v = 1'b0; req1_t = 1'b0; req1_d = 128'd0;
    s4_req0_v = 1'b0; s4_req0_t = 1'b0; s4_req0_d = 128'd0;
    s4_req1_v = 1'b0; s4_req1_t = 1'b0; s4_req1_d = 128'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Ticks until ser_vin is seen or max cycles elapse; n = cycles taken.
  task automatic wait_pulse(input int max, output int n, output bit seen);
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (ser_vin === 1'b1) begin
        n = i;
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    checks++; if (req0_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy0: got %b expected 1", req0_rdy); end
    checks++; if (req1_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy1: got %b expected 1", req1_rdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ser_vin !== 1'b0) begin errors++; $display("FAIL reset_vin: got %b expected 0", ser_vin); end
    checks++; if (ser_tin !== 1'b0) begin errors++; $display("FAIL reset_tin: got %b expected 0", ser_tin); end
    checks++; if (ser_din !== 128'd0) begin errors++; $display("FAIL reset_din: got %h expected 0", ser_din); end
    checks++; if (ser_src !== 1'b0) begin errors++; $display("FAIL reset_src: got %b expected 0", ser_src); end
    checks++; if (s4_busy !== 1'b0 || s4_ser_din !== 128'd0) begin errors++; $display("FAIL reset_s4: busy %b din %h expected 0/0", s4_busy, s4_ser_din); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req0_v = 1'b1; req0_d = DA; req0_t = 1'b1;
    tick();  // accept edge
    checks++; if (req0_rdy !== 1'b0) begin errors++; $display("FAIL single_rdy_after_accept: got %b expected 0", req0_rdy); end
    checks++; if (ser_vin !== 1'b0) begin errors++; $display("FAIL single_vin_early: got %b expected 0", ser_vin); end
    req0_v = 1'b0; req0_d = DB; req0_t = 1'b0;
    tick();  // grant edge
    checks++; if (ser_vin !== 1'b1) begin errors++; $display("FAIL single_vin: got %b expected 1", ser_vin); end
    checks++; if (ser_din !== DA) begin errors++; $display("FAIL single_din: got %h expected %h", ser_din, DA); end
    checks++; if (ser_tin !== 1'b1) begin errors++; $display("FAIL single_tin: got %b expected 1", ser_tin); end
    checks++; if (ser_src !== 1'b0) begin errors++; $display("FAIL single_src: got %b expected 0", ser_src); end
    checks++; if (req0_rdy !== 1'b1) begin errors++; $display("FAIL single_rdy_after_grant: got %b expected 1", req0_rdy); end
    tick();
    checks++; if (ser_vin !== 1'b0) begin errors++; $display("FAIL single_vin_one_cycle: got %b expected 0", ser_vin); end
    checks++; if (ser_din !== DA) begin errors++; $display("FAIL single_din_hold: got %h expected %h", ser_din, DA); end
    repeat (5) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_cnt1: got %b expected 1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_contention();
    int n;
    bit seen;
    do_reset();
    req0_v = 1'b1; req0_d = DA; req0_t = 1'b0;
    req1_v = 1'b1; req1_d = DB; req1_t = 1'b1;
    tick();
    idle_inputs();
    tick();
    checks++; if (ser_vin !== 1'b1 || ser_src !== 1'b0) begin errors++; $display("FAIL cont_first: vin %b src %b expected 1/0", ser_vin, ser_src); end
    checks++; if (ser_din !== DA || ser_tin !== 1'b0) begin errors++; $display("FAIL cont_first_data: got %h/%b expected %h/0", ser_din, ser_tin, DA); end
    wait_pulse(20, n, seen);
    checks++; if (!seen || n != 8) begin errors++; $display("FAIL cont_gap: got %0d (seen %b) expected 8", n, seen); end
    checks++; if (ser_src !== 1'b1) begin errors++; $display("FAIL cont_second_src: got %b expected 1", ser_src); end
    checks++; if (ser_din !== DB || ser_tin !== 1'b1) begin errors++; $display("FAIL cont_second_data: got %h/%b expected %h/1", ser_din, ser_tin, DB); end
  endtask

  task automatic test_backpressure();
    logic [127:0] dc;
    int n;
    bit seen;
    dc = 128'hC0C0_C0C0_1234_5678_9ABC_DEF0_0F0F_0F0F;
    do_reset();
    req1_v = 1'b1; req1_d = DA; req1_t = 1'b0;
    tick();  // accept DA
    checks++; if (req1_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy_full: got %b expected 0", req1_rdy); end
    req1_d = DB; req1_t = 1'b1;  // offered while not ready: must be ignored
    tick();  // grant DA
    checks++; if (ser_vin !== 1'b1 || ser_din !== DA || ser_src !== 1'b1 || ser_tin !== 1'b0) begin
      errors++; $display("FAIL bp_first: vin %b din %h src %b tin %b expected 1/%h/1/0", ser_vin, ser_din, ser_src, ser_tin, DA);
    end
    req1_d = dc; req1_t = 1'b1;
    tick();  // accept dc
    checks++; if (req1_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy_refull: got %b expected 0", req1_rdy); end
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      req1_d = {4{32'hBAD0_0000 + 32'(i)}};
      req1_t = 1'b0;
      tick();
      if (ser_vin === 1'b1) begin
        seen = 1'b1;
        n = i;
        break;
      end
    end
    req1_v = 1'b0;
    checks++; if (!seen || n != 7) begin errors++; $display("FAIL bp_gap: got %0d (seen %b) expected 7", n, seen); end
    checks++; if (ser_din !== dc || ser_tin !== 1'b1) begin errors++; $display("FAIL bp_data: got %h/%b expected %h/1", ser_din, ser_tin, dc); end
    tick();
    checks++; if (req1_rdy !== 1'b1) begin errors++; $display("FAIL bp_no_extra_accept: got %b expected 1", req1_rdy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0_v = 1'b1; req0_d = mk(1'b0, 100); req0_t = 1'b0;
    req1_v = 1'b1; req1_d = mk(1'b1, 200); req1_t = 1'b0;
    tick();  // accept both
    req1_v = 1'b0;
    req0_d = mk(1'b0, 101);
    tick();  // grant 0, cnt=7
    checks++; if (ser_vin !== 1'b1 || ser_src !== 1'b0) begin errors++; $display("FAIL rm_first: vin %b src %b expected 1/0", ser_vin, ser_src); end
    tick();  // re-accept slot 0, cnt=6
    req0_v = 1'b0;
    checks++; if (req0_rdy !== 1'b0 || req1_rdy !== 1'b0) begin errors++; $display("FAIL rm_both_full: rdy %b%b expected 00", req0_rdy, req1_rdy); end
    tick();  // cnt=5
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (ser_vin !== 1'b0) begin errors++; $display("FAIL rm_vin_at_reset: got %b expected 0", ser_vin); end
    checks++; if (req0_rdy !== 1'b1 || req1_rdy !== 1'b1) begin errors++; $display("FAIL rm_rdy: got %b%b expected 11", req0_rdy, req1_rdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", busy); end
    tick();
    checks++; if (ser_vin !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_after: vin %b busy %b expected 0/0", ser_vin, busy); end
    req1_v = 1'b1; req1_d = DB; req1_t = 1'b1;
    tick();
    req1_v = 1'b0;
    checks++; if (ser_vin !== 1'b0) begin errors++; $display("FAIL rm_new_early: got %b expected 0", ser_vin); end
    tick();
    checks++; if (ser_vin !== 1'b1 || ser_src !== 1'b1 || ser_din !== DB || ser_tin !== 1'b1) begin
      errors++; $display("FAIL rm_new_block: vin %b src %b din %h tin %b expected 1/1/%h/1", ser_vin, ser_src, ser_din, ser_tin, DB);
    end
  endtask

  task automatic test_saturation();
    int n0, n1, e0, e1, pulses, last;
    bit exp_src, a0, a1;
    logic [31:0] ev;
    do_reset();
    n0 = 0; n1 = 0; e0 = 0; e1 = 0; pulses = 0; last = 0; exp_src = 1'b0;
    req0_v = 1'b1; req0_d = mk(1'b0, 0); req0_t = 1'b0;
    req1_v = 1'b1; req1_d = mk(1'b1, 0); req1_t = 1'b0;
    for (int cyc = 1; cyc <= 400 && pulses < 40; cyc++) begin
      a0 = req0_rdy;
      a1 = req1_rdy;
      tick();
      if (a0) begin n0++; ev = n0; req0_d = mk(1'b0, n0); req0_t = ev[0]; end
      if (a1) begin n1++; ev = n1; req1_d = mk(1'b1, n1); req1_t = ev[0]; end
      if (ser_vin === 1'b1) begin
        ev = exp_src ? e1 : e0;
        checks++; if (ser_src !== exp_src) begin errors++; $display("FAIL sat_src[%0d]: got %b expected %b", pulses, ser_src, exp_src); end
        checks++; if (ser_din !== mk(exp_src, int'(ev)) || ser_tin !== ev[0]) begin
          errors++; $display("FAIL sat_data[%0d]: got %h/%b expected %h/%b", pulses, ser_din, ser_tin, mk(exp_src, int'(ev)), ev[0]);
        end
        if (pulses > 0) begin
          checks++; if (cyc - last != 8) begin errors++; $display("FAIL sat_gap[%0d]: got %0d expected 8", pulses, cyc - last); end
        end
        if (exp_src) e1++; else e0++;
        last = cyc;
        exp_src = ~exp_src;
        pulses++;
      end
    end
    checks++; if (pulses != 40) begin errors++; $display("FAIL sat_count: got %0d expected 40", pulses); end
    idle_inputs();
  endtask

  task automatic test_slot4();
    int pulses, last;
    bit exp_src;
    do_reset();
    pulses = 0; last = 0; exp_src = 1'b0;
    s4_req0_v = 1'b1; s4_req0_d = DA;
    s4_req1_v = 1'b1; s4_req1_d = DB;
    for (int cyc = 1; cyc <= 80 && pulses < 8; cyc++) begin
      tick();
      if (s4_ser_vin === 1'b1) begin
        checks++; if (s4_ser_src !== exp_src) begin errors++; $display("FAIL s4_src[%0d]: got %b expected %b", pulses, s4_ser_src, exp_src); end
        if (pulses > 0) begin
          checks++; if (cyc - last != 4) begin errors++; $display("FAIL s4_gap[%0d]: got %0d expected 4", pulses, cyc - last); end
        end
        last = cyc;
        exp_src = ~exp_src;
        pulses++;
      end
    end
    checks++; if (pulses != 8) begin errors++; $display("FAIL s4_count: got %0d expected 8", pulses); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_slot4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
